// File: rtl/alu_control_mc.sv
// EX-stage ALU control: decodes ALUOp/FuncCode into ALU_Cntrl and runs an
// iterative shift-add multiply, stalling the pipeline while it is in flight.
module alu_control_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       FuncCode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       ALU_Cntrl,
    output logic             is_mul,
    output logic             stall,
    output logic             mul_done,
    output logic [WIDTH-1:0] mul_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             start;

    always_comb begin
        ALU_Cntrl = 4'b0010;
        is_mul    = 1'b0;
        unique case (ALUOp)
            2'b00: ALU_Cntrl = 4'b0010;
            2'b01: ALU_Cntrl = 4'b0110;
            2'b10: begin
                unique case (FuncCode)
                    3'b000:  ALU_Cntrl = 4'b0010;
                    3'b001:  ALU_Cntrl = 4'b0110;
                    3'b010:  ALU_Cntrl = 4'b0000;
                    3'b011:  ALU_Cntrl = 4'b0001;
                    3'b100:  ALU_Cntrl = 4'b0111;
                    3'b101: begin
                        ALU_Cntrl = 4'b0010;
                        is_mul    = 1'b1;
                    end
                    default: ALU_Cntrl = 4'b0010;
                endcase
            end
            default: ALU_Cntrl = 4'b0010;
        endcase
    end

    assign start = valid_in & is_mul & ~flush;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    a_d     = src_a;
                    b_d     = src_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Publish the sum including this final partial product.
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        res_d   = acc_d;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign mul_done   = done_q;
    assign mul_result = res_q;

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Parametrised, multi-cycle-capable ALU control stage for the EX stage of the pipelined core. It decodes `ALUOp`/`FuncCode` into the 4-bit `ALU_Cntrl` code consumed by the single-cycle ALU. It adds SUB, AND, SLT and an iterative shift-add multiply (MUL) whose operands it captures and sequences internally. While a MUL is in flight it raises `stall` to freeze IF/ID/EX, and it publishes the product with a one-cycle `mul_done` pulse.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; MUL iterates exactly `WIDTH` cycles.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

Ports:
- `clk`  in  1  single clock, all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  EX holds a valid instruction this cycle.
- `flush`  in  1  synchronous abort from hazard/branch unit.
- `ALUOp`  in  2  from the main control unit.
- `FuncCode`  in  3  funct field of an R-type instruction.
- `src_a`  in  WIDTH  forwarded operand A.
- `src_b`  in  WIDTH  forwarded operand B.
- `ALU_Cntrl`  out  4  combinational code to the single-cycle ALU.
- `is_mul`  out  1  combinational: current decode is MUL.
- `stall`  out  1  combinational pipeline freeze request.
- `mul_done`  out  1  registered one-cycle completion pulse.
- `mul_result`  out  WIDTH  registered low WIDTH bits of the last completed product.

## Operation
Decode (combinational, independent of state):
- `ALUOp` 00 -> 0010 ADD (load/store).
- `ALUOp` 01 -> 0110 SUB (branch compare).
- `ALUOp` 10, `FuncCode` 000 ADD 0010, 001 SUB 0110, 010 AND 0000, 011 OR 0001, 100 SLT 0111, 101 MUL 0010 with `is_mul`=1.
- `ALUOp` 10, any other `FuncCode` -> 0010.
- `ALUOp` 11 -> 0010.

FSM states: IDLE, MUL, DONE.
- IDLE: on `valid_in & is_mul & ~flush`, load `a_reg`=`src_a` and `b_reg`=`src_b`, set `acc`=0 and `cnt`=0, then go to MUL.
- MUL: each cycle, if `b_reg[0]` then `acc` += `a_reg` (mod 2^WIDTH). Then `a_reg` <<= 1, `b_reg` >>= 1, `cnt`++. When `cnt` == WIDTH-1 on that update, go to DONE.
- Entering DONE: `mul_result` <= final `acc`, `mul_done` <= 1.
- DONE: go to IDLE unconditionally. The held MUL instruction advances this cycle and does not restart.
- `stall` = (IDLE & `valid_in` & `is_mul` & ~`flush`) | MUL.
- `stall` is 0 in DONE.
- Arithmetic is unsigned modulo 2^WIDTH. The low half is correct for two's-complement operands.
- `flush` in MUL or DONE: go to IDLE next edge. `acc` is discarded, `mul_done` stays 0 (or is cleared), and `mul_result` keeps its previous value.
- `flush` has priority over start and completion.

## Timing
- Reset values: state IDLE, `cnt` 0, `a_reg`/`b_reg`/`acc` 0, `mul_result` 0, `mul_done` 0. `stall` is 0 unless `valid_in & is_mul`.
- Reset asserted mid-MUL aborts immediately and asynchronously. After release the block is in IDLE, with no `mul_done` and `mul_result`=0.
- MUL accepted at edge-cycle T0 (IDLE):
  - MUL state occupies T1..T`WIDTH`.
  - DONE at T(`WIDTH`+1), with `mul_done`=1 and `mul_result` valid.
  - `stall` is high T0..T`WIDTH` (`WIDTH`+1 cycles).
- Back-to-back MUL: a second MUL is accepted in the IDLE cycle immediately after DONE, giving 1 non-stalled cycle between products.
- Non-MUL ops: zero latency, `stall` never asserted.
- `src_a`/`src_b` changes after T0 do not affect the product.

## Test plan
- Decode sweep over all 32 `ALUOp`/`FuncCode` combinations with `valid_in`=1 -> `ALU_Cntrl` matches the table, `is_mul` only for 10/101, `stall` only for 10/101.
- WIDTH=32, MUL 7×6 at T0, operands changed at T1 -> `stall` high 33 cycles, `mul_done` pulse at T33, `mul_result`=42.
- MUL 0xFFFFFFFF×2 -> 0xFFFFFFFE. Then MUL 0×0x1234 -> 0, with `mul_done` still at T33.
- Previous result 42, then `flush` at T10 of a 3×5 MUL -> `stall` low from T11, no `mul_done`, `mul_result` remains 42. Next MUL 3×5 -> 15.
- `rst_n` low at T20 of a MUL -> outputs take their reset values without a clock edge. After release, a MUL 9×9 yields 81 at T33.
- Two consecutive MULs (2×3, 4×5) -> `mul_done` at T33 and T67, results 6 then 20, `stall` low only at T33.
